// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and occupancy flags.
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_ERR_FLAGS_EN is defined.
//
// Parameters:
//   DATA_W    - word width in bits (>= 1)
//   DEPTH     - number of stored words (power of two, >= 2)
//   AFULL_TH  - almost_full asserts when count >= AFULL_TH (1..DEPTH)
//   AEMPTY_TH - almost_empty asserts when count <= AEMPTY_TH (0..DEPTH-1)
//
// Ports:
//   clk          in   clock, all state changes on the rising edge
//   rst          in   synchronous active-high reset
//   wr_en        in   write request, accepted when not full
//   wr_data      in   write word
//   rd_en        in   read request, accepted when not empty
//   rd_data      out  registered read word, loaded on an accepted read
//   full         out  count == DEPTH
//   empty        out  count == 0
//   almost_full  out  count >= AFULL_TH
//   almost_empty out  count <= AEMPTY_TH
//   count        out  occupancy, 0..DEPTH
//   overflow     out  sticky: wr_en seen while full (SYNC_FIFO_ERR_FLAGS_EN only)
//   underflow    out  sticky: rd_en seen while empty (SYNC_FIFO_ERR_FLAGS_EN only)

module sync_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    output logic                       overflow,
    output logic                       underflow,
`endif
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AFULL  = CW'(AFULL_TH);
    localparam logic [CW-1:0] CNT_AEMPTY = CW'(AEMPTY_TH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic full_w;
    logic empty_w;
    logic wr_acc;
    logic rd_acc;

    // Status flags look only at the count register, so no input
    // reaches an output combinationally.
    assign full_w  = (count_q == CNT_FULL);
    assign empty_w = (count_q == '0);

    // Blocked requests are simply not accepted; when full with both
    // requests only the read goes through, when empty only the write.
    assign wr_acc = wr_en && !full_w;
    assign rd_acc = rd_en && !empty_w;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        if (rd_acc) begin
            rd_ptr_d  = rd_ptr_q + AW'(1);
            rd_data_d = mem_q[rd_ptr_q];
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage is never cleared; reset only discards it via the pointers.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_en && full_w) begin
            overflow_d = 1'b1;
        end
        if (rd_en && empty_w) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

    assign rd_data      = rd_data_q;
    assign count        = count_q;
    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = (count_q >= CNT_AFULL);
    assign almost_empty = (count_q <= CNT_AEMPTY);

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed table-driven bench for sync_fifo (DATA_W=8, DEPTH=8).
// Error-flag checks are compiled when SYNC_FIFO_ERR_FLAGS_EN is defined.

module tb_sync_fifo;

    localparam int DW  = 8;
    localparam int DEP = 8;
    localparam int AF  = 6;
    localparam int AE  = 1;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [3:0]    count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    int n_tests;
    int n_fail;

    sync_fifo #(
        .DATA_W(DW),
        .DEPTH(DEP),
        .AFULL_TH(AF),
        .AEMPTY_TH(AE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .overflow(overflow),
        .underflow(underflow),
`endif
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       we;
        logic [7:0] wd;
        logic       re;
        int         cnt;
        logic [7:0] rdd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic we, input logic [7:0] wd,
                        input logic re);
        rst     = r;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic chk_state(input string name, input int cnt,
                             input logic [7:0] rdd);
        chk({name, ".count"}, int'(count), cnt);
        chk({name, ".rd_data"}, int'(rd_data), int'(rdd));
        chk({name, ".full"}, int'(full), int'(cnt == DEP));
        chk({name, ".empty"}, int'(empty), int'(cnt == 0));
        chk({name, ".afull"}, int'(almost_full), int'(cnt >= AF));
        chk({name, ".aempty"}, int'(almost_empty), int'(cnt <= AE));
    endtask

    function automatic vec_t mk(input logic r, input logic we, input int wd,
                                input logic re, input int cnt, input int rdd);
        vec_t v;
        v.rst = r;
        v.we  = we;
        v.wd  = 8'(wd);
        v.re  = re;
        v.cnt = cnt;
        v.rdd = 8'(rdd);
        return v;
    endfunction

    logic [7:0] q[$];
    logic [7:0] exp_rd;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;

        // Reset, fill 0x01..0x08, blocked write, drain, blocked read,
        // both-on-empty, then read back the one word.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 8; i++) vecs.push_back(mk(0, 1, i, 0, i, 0));
        vecs.push_back(mk(0, 1, 8'h09, 0, 8, 0));
        for (int i = 1; i <= 8; i++) vecs.push_back(mk(0, 0, 0, 1, 8 - i, i));
        vecs.push_back(mk(0, 0, 0, 1, 0, 8'h08));
        vecs.push_back(mk(0, 1, 8'h55, 1, 1, 8'h08));
        vecs.push_back(mk(0, 0, 0, 1, 0, 8'h55));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h55));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].we, vecs[i].wd, vecs[i].re);
            chk_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].rdd);
        end

        // Pointer wrap: 5 in/out, then 7 more that straddle the wrap.
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h10 + i), 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1);
            chk($sformatf("wrap1.rd%0d", i), int'(rd_data), 8'h10 + i);
        end
        for (int i = 0; i < 7; i++) step(0, 1, 8'(8'hA0 + i), 0);
        chk_state("wrap.filled", 7, 8'h14);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 0, 1);
            chk($sformatf("wrap2.rd%0d", i), int'(rd_data), 8'hA0 + i);
        end
        chk_state("wrap.drained", 0, 8'hA6);

        // Simultaneous read/write at count 4.
        step(1, 0, 0, 0);
        q.delete();
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 8'(8'hB0 + i), 0);
            q.push_back(8'(8'hB0 + i));
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 8'(8'hC0 + i), 1);
            exp_rd = q.pop_front();
            q.push_back(8'(8'hC0 + i));
            chk_state($sformatf("sim%0d", i), 4, exp_rd);
        end

        // Full with both requests: only the read is taken.
        step(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h30 + i), 0);
        step(0, 1, 8'hEE, 1);
        chk_state("full_both", 7, 8'h30);
        for (int i = 1; i < 8; i++) begin
            step(0, 0, 0, 1);
            chk($sformatf("full_both.rd%0d", i), int'(rd_data), 8'h30 + i);
        end
        chk_state("full_both.end", 0, 8'h37);

        // Empty with both requests: only the write is taken.
        step(1, 0, 0, 0);
        step(0, 1, 8'h77, 1);
        chk_state("empty_both", 1, 8'h00);
        step(0, 0, 0, 1);
        chk_state("empty_both.rd", 0, 8'h77);

        // Reset mid-operation with a write pending.
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h60 + i), 0);
        step(0, 0, 0, 1);
        chk_state("pre_rst", 4, 8'h60);
        step(1, 1, 8'h99, 0);
        chk_state("mid_rst", 0, 8'h00);
        step(0, 0, 0, 1);
        chk_state("post_rst_rd", 0, 8'h00);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
        step(1, 0, 0, 0);
        chk("err.rst_ovf", int'(overflow), 0);
        chk("err.rst_udf", int'(underflow), 0);
        for (int i = 0; i < 8; i++) step(0, 1, 8'(i), 0);
        chk("err.no_ovf", int'(overflow), 0);
        step(0, 1, 8'hFF, 0);
        chk("err.ovf", int'(overflow), 1);
        step(0, 0, 0, 1);
        chk("err.ovf_sticky", int'(overflow), 1);
        chk("err.no_udf", int'(underflow), 0);
        step(1, 0, 0, 0);
        chk("err.ovf_clr", int'(overflow), 0);
        step(0, 0, 0, 1);
        chk("err.udf", int'(underflow), 1);
        step(0, 1, 8'h01, 0);
        chk("err.udf_sticky", int'(underflow), 1);
        step(1, 0, 0, 0);
        chk("err.udf_clr", int'(underflow), 0);
        chk("err.ovf_clr2", int'(overflow), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
